// File: rtl/apb_cmd_master_if.sv
// rtl/apb_cmd_master_if.sv - APB3 bus bundle shared by the command master and its slaves
interface apb_cmd_master_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 2
) ();
  logic [NUM_SLAVES-1:0] PSEL;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - APB3 initiator turning a command stream into single transfers with one response each
module apb_cmd_master #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [3:0]            cmd_sel,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  apb_cmd_master_if.master      apb
);

  localparam int  CW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit  TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state;
  logic [CW-1:0]         wait_cnt;
  logic [NUM_SLAVES-1:0] sel_onehot;
  logic                  sel_ok;
  logic                  to_hit;

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_onehot[i] = (int'(cmd_sel) == i);
    end
    sel_ok = (int'(cmd_sel) < NUM_SLAVES);
  end

  // This edge is the TIMEOUT-th consecutive PREADY-low edge of the access phase.
  assign to_hit = TO_EN && ((int'(wait_cnt) + 1) >= TIMEOUT);

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      apb.PSEL    <= '0;
      apb.PADDR   <= '0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PWDATA  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (sel_ok) begin
              apb.PSEL   <= sel_onehot;
              apb.PADDR  <= cmd_addr;
              apb.PWRITE <= cmd_write;
              apb.PWDATA <= cmd_wdata;
              wait_cnt   <= '0;
              state      <= SETUP;
            end else begin
              // Unmapped slave index: answer with an error, never touch the bus.
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= '0;
              state       <= RESP;
            end
          end
        end
        SETUP: begin
          apb.PENABLE <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (apb.PREADY) begin
            rsp_rdata   <= apb.PWRITE ? '0 : apb.PRDATA;
            rsp_err     <= apb.PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            apb.PSEL    <= '0;
            apb.PENABLE <= 1'b0;
            state       <= RESP;
          end else if (to_hit) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            apb.PSEL    <= '0;
            apb.PENABLE <= 1'b0;
            state       <= RESP;
          end else if (wait_cnt != {CW{1'b1}}) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
